paralelo_serial_param: RTL and testbench

- Parametrised parallel-to-serial converter for the PCIe physical-layer TX path.
- Runs entirely on the serial clock clk_32f. It accepts WIDTH-bit words through a valid/ready handshake into a small FIFO and serialises them MSB first.
- Sends IDLE_SYM whenever no word is available at a symbol boundary.
- After reset, a training phase of TRAIN_SYMS idle symbols must complete before input is accepted.

---
 rtl/paralelo_serial_pkg.sv | 13 +
 rtl/ps_fifo.sv | 42 ++++
 rtl/paralelo_serial_param.sv | 91 +++++++++
 tb/tb_paralelo_serial_param.sv | 104 ++++++++++
 4 files changed

// File: rtl/paralelo_serial_pkg.sv
// paralelo_serial_pkg: shared FSM state type, default idle symbol and frame length.
// FRAME grows by one parity bit when PS_PARITY_EN is defined.
package paralelo_serial_pkg;
    typedef enum logic {TRAIN, ACTIVE} state_t;
    localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;
    function automatic int frame_len(input int width);
`ifdef PS_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction
endpackage

// File: rtl/ps_fifo.sv
// ps_fifo: synchronous FIFO with occupancy count and registered head storage.
module ps_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_32f,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr, w_rd;
    assign full  = r_count == CW'(DEPTH);
    assign empty = r_count == '0;
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];
    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
        end
    end
    always_ff @(posedge clk_32f) begin
        if (w_wr) r_mem[r_wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/paralelo_serial_param.sv
// paralelo_serial_param: FIFO-fed MSB-first serialiser with idle fill and post-reset training.
// Define PS_PARITY_EN to append an even-parity bit to every symbol.
module paralelo_serial_param
    import paralelo_serial_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(IDLE_SYM_DEF),
    parameter int               TRAIN_SYMS = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             in_ready,
    output logic             data_out,
    output logic             sym_start,
    output logic             is_idle
);
    localparam int FRAME = frame_len(WIDTH);
    localparam int BW    = $clog2(FRAME);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int TW    = $clog2(TRAIN_SYMS+1);
    localparam logic [BW-1:0] LAST = BW'(FRAME-1);
    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_train_cnt;
    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift, w_head, w_word;
    logic [CW-1:0]    w_count, w_count_nxt;
    logic             r_data_out, r_sym_start, r_is_idle, r_in_ready;
    logic             w_boundary, w_full, w_empty, w_wr, w_rd;
`ifdef PS_PARITY_EN
    logic             r_par;
`endif
    ps_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk_32f(clk_32f), .reset(reset), .wr_en(w_wr), .wr_data(data_in), .rd_en(w_rd),
        .full(w_full), .empty(w_empty), .count(w_count), .head(w_head)
    );
    assign w_boundary  = r_bit_cnt == '0;
    assign w_wr        = valid_in && r_in_ready && !w_full;
    assign w_rd        = w_boundary && r_state == ACTIVE && !w_empty;
    assign w_word      = w_rd ? w_head : IDLE_SYM;
    assign w_count_nxt = w_count + CW'(w_wr) - CW'(w_rd);
    assign in_ready    = r_in_ready;
    assign data_out    = r_data_out;
    assign sym_start   = r_sym_start;
    assign is_idle     = r_is_idle;
    always_comb begin
        w_state_nxt = (r_state == TRAIN && r_train_cnt == TW'(TRAIN_SYMS) && r_bit_cnt == LAST) ? ACTIVE : r_state;
    end
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) r_state <= TRAIN;
        else       r_state <= w_state_nxt;
    end
    // in_ready looks at the post-edge occupancy so a full FIFO never sees a write
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_train_cnt <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data_out  <= 1'b0;
            r_sym_start <= 1'b0;
            r_is_idle   <= 1'b0;
            r_in_ready  <= 1'b0;
`ifdef PS_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_in_ready <= w_state_nxt == ACTIVE && w_count_nxt != CW'(DEPTH);
            r_bit_cnt  <= (r_bit_cnt == LAST) ? '0 : r_bit_cnt + 1'b1;
            if (w_boundary) begin
                r_shift     <= w_word << 1;
                r_data_out  <= w_word[WIDTH-1];
                r_sym_start <= 1'b1;
                r_is_idle   <= !w_rd;
`ifdef PS_PARITY_EN
                r_par       <= ^w_word;
`endif
                if (r_state == TRAIN) r_train_cnt <= r_train_cnt + 1'b1;
            end else begin
                r_sym_start <= 1'b0;
                r_shift     <= r_shift << 1;
`ifdef PS_PARITY_EN
                r_data_out  <= (r_bit_cnt == LAST) ? r_par : r_shift[WIDTH-1];
`else
                r_data_out  <= r_shift[WIDTH-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_paralelo_serial_param.sv
// tb_paralelo_serial_param: directed checks of training, streaming, full FIFO and reset abort.
// Exercises the default build (8-bit words, no parity).
module tb_paralelo_serial_param;
    logic       clk_32f = 1'b0;
    logic       reset = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       in_ready, data_out, sym_start, is_idle;
    logic [8:0] stim_q[$];
    int         checks = 0;
    int         failures = 0;

    paralelo_serial_param dut (
        .clk_32f(clk_32f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .in_ready(in_ready), .data_out(data_out), .sym_start(sym_start), .is_idle(is_idle)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock: present the next queued input beat, then sample at the falling edge
    task automatic step();
        logic [8:0] s;
        s = (stim_q.size() > 0) ? stim_q.pop_front() : 9'h000;
        valid_in = s[8];
        data_in  = s[7:0];
        @(negedge clk_32f);
    endtask

    task automatic sym(input string tag, input logic [7:0] e_sym, input logic [7:0] e_idl,
                       input logic [7:0] e_rdy);
        logic [7:0] d, ss, idl, rdy;
        for (int i = 7; i >= 0; i--) begin
            step();
            d[i] = data_out; ss[i] = sym_start; idl[i] = is_idle; rdy[i] = in_ready;
        end
        chk({tag, ".data"}, d, e_sym);
        chk({tag, ".sym_start"}, ss, 8'h80);
        chk({tag, ".is_idle"}, idl, e_idl);
        chk({tag, ".in_ready"}, rdy, e_rdy);
    endtask

    initial begin
        logic [2:0] part;
        repeat (2) @(negedge clk_32f);
        chk("rst.data_out", data_out, 0);
        chk("rst.sym_start", sym_start, 0);
        chk("rst.is_idle", is_idle, 0);
        chk("rst.in_ready", in_ready, 0);
        reset = 1'b0;
        sym("train1", 8'hBC, 8'hFF, 8'h00);
        sym("train2", 8'hBC, 8'hFF, 8'h00);
        sym("train3", 8'hBC, 8'hFF, 8'h00);
        sym("train4", 8'hBC, 8'hFF, 8'h01);
        stim_q = '{9'h1AB, 9'h1CA, 9'h112};
        sym("b2b.idle", 8'hBC, 8'hFF, 8'hFF);
        sym("b2b.ab", 8'hAB, 8'h00, 8'hFF);
        sym("b2b.ca", 8'hCA, 8'h00, 8'hFF);
        sym("b2b.12", 8'h12, 8'h00, 8'hFF);
        sym("b2b.tail", 8'hBC, 8'hFF, 8'hFF);
        stim_q = '{9'h000, 9'h000, 9'h111, 9'h122, 9'h133, 9'h144, 9'h155};
        sym("full.fill", 8'hBC, 8'hFF, 8'hF8);
        sym("full.w1", 8'h11, 8'h00, 8'hFF);
        sym("full.w2", 8'h22, 8'h00, 8'hFF);
        sym("full.w3", 8'h33, 8'h00, 8'hFF);
        sym("full.w4", 8'h44, 8'h00, 8'hFF);
        sym("full.tail", 8'hBC, 8'hFF, 8'hFF);
        stim_q = '{9'h000, 9'h000, 9'h15A};
        sym("wp.load", 8'hBC, 8'hFF, 8'hFF);
        stim_q = '{9'h1FA};
        sym("wp.5a", 8'h5A, 8'h00, 8'hFF);
        sym("wp.fa", 8'hFA, 8'h00, 8'hFF);
        sym("wp.tail", 8'hBC, 8'hFF, 8'hFF);
        stim_q = '{9'h000, 9'h1CA, 9'h133, 9'h177};
        sym("rm.load", 8'hBC, 8'hFF, 8'hFF);
        for (int i = 2; i >= 0; i--) begin
            step();
            part[i] = data_out;
        end
        chk("rm.ca_head", part, 3'b110);
        reset = 1'b1;
        #1;
        chk("rm.data_out", data_out, 0);
        chk("rm.in_ready", in_ready, 0);
        chk("rm.sym_start", sym_start, 0);
        @(negedge clk_32f);
        reset = 1'b0;
        sym("retrain1", 8'hBC, 8'hFF, 8'h00);
        sym("retrain2", 8'hBC, 8'hFF, 8'h00);
        sym("retrain3", 8'hBC, 8'hFF, 8'h00);
        sym("retrain4", 8'hBC, 8'hFF, 8'h01);
        sym("rm.post1", 8'hBC, 8'hFF, 8'hFF);
        sym("rm.post2", 8'hBC, 8'hFF, 8'hFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
